fpregfile_mt: RTL and testbench
===============================

# fpregfile_mt

Parametrised multi-threaded floating-point register file. It serves NRD independent single-cycle read ports and one 64-bit paired write port. It runs in a single clock domain with no double-clocked read multiplexing, and adds:
- per-byte parity check with sticky error counting,
- same-cycle write-to-read bypass,
- a post-reset zeroing sweep.

It sits between the FP issue/decode stage (reads) and FP commit (writes), replacing the double-clocked 2-read register file in the FPU pipeline.

## Interface
Parameters:
- NTHREAD, 64, hardware threads; power of 2.
- NREG, 32, 32-bit FP registers per thread; power of 2, ≥2.
- NRD, 4, read ports.
- PARITY, 1, 1 = store and check parity; 0 = parity outputs tied 0.

Ports (TW = $clog2(NTHREAD), RW = $clog2(NREG)):
- gclk  in  iu_clk_type  clock bundle; only gclk.clk used, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rd_tid[NRD]  in  TW  read thread id per port.
- rd_reg[NRD]  in  RW  read register index per port.
- rd_data[NRD]  out  32  registered read data.
- rd_perr[NRD]  out  1  registered parity error for that read.
- wr_tid  in  TW  write thread id.
- wr_pair  in  RW-1  register-pair index; registers 2·wr_pair (even) and 2·wr_pair+1 (odd).
- wr_we  in  2  [0] writes the even word, [1] writes the odd word.
- wr_data  in  64  {odd word, even word}.
- wr_inj  in  1  test hook: invert parity bit 0 of each word written this cycle.
- ready  out  1  high once the init sweep has completed.
- perr_count  out  8  saturating count of flagged reads.
- perr_clear  in  1  zero perr_count.

## Operation
- Storage is two banks, even and odd. Each bank is NTHREAD·NREG/2 entries × (32 data + 4 parity). Entry address is {tid, reg[RW-1:1]}.
- Parity: one even-parity bit per byte, generated on write and checked on read. With PARITY=0, parity is neither stored nor checked.
- Read: bank select is rd_reg[0]. The returned word is always the addressed 32-bit register; no caller-side lane select is needed.
- Bypass: if a read in cycle t addresses a word written in cycle t (wr_we bit set, tid and pair match, ready=1), rd_data returns the new wr_data word. Parity for the bypassed word is the generated parity, including wr_inj, so injection is also detectable through the bypass path.
- FSM states:
  - INIT: a counter sweeps entry 0 to NTHREAD·NREG/2−1, writing zero data with correct parity to both banks. External writes are dropped. Reads return rd_data=0 and rd_perr=0. perr_count does not count.
  - READY: normal operation. The transition occurs after the last sweep write, and ready=1 from the following cycle.
- rst in any state, including mid-sweep, forces INIT and resets the counter to 0.
- perr_count: each cycle it adds the number of ports with rd_perr=1, saturating at 255. perr_clear has priority: the count becomes 0 that cycle and that cycle's errors are discarded.

## Timing
- Reset values: rd_data=0, rd_perr=0, ready=0, perr_count=0, sweep counter=0, state INIT.
- Read latency is 1: addresses sampled at edge t give rd_data and rd_perr valid after edge t+1. Fully pipelined, one read per port per cycle.
- Write takes effect at the edge. Read-during-write to the same word is write-first via the bypass.
- Init sweep takes exactly NTHREAD·NREG/2 cycles (1024 with defaults) after rst deasserts. ready rises on the next cycle.
- All NRD ports may address the same word in the same cycle, and all see identical data.
- wr_we=00 is a no-op, and wr_inj is then ignored.

## Structure
- The shared FP package (libfp) holds:
  - the byte-parity generate/check function,
  - an fpregfile_mt state enum {INIT, READY},
  - read-request and read-response struct typedefs parametrised on TW/RW.
- Sub-module fpregfile_bank: 1 write / 1 read, 36-bit wide, depth NTHREAD·NREG/2, registered read, synchronous rst on the output register only.
  - The top instantiates 2·NRD copies (even and odd per read port).
  - All copies are written identically, so each port gets a private read port; this maps to BRAM on Virtex-5.
- The top holds the sweep FSM, bypass compare, parity check and error counter.

## Test plan
- Reset, then count cycles: ready rises exactly 1024 cycles after rst falls. A read of tid 63 reg 31 then returns 0 with rd_perr=0.
- Write tid 5, pair 3, we=11, data 64'h40000000_3F800000. Next cycle, ports 0/1 read reg 6/reg 7. One cycle later they return 3F800000 and 40000000, with no errors.
- Same-cycle bypass: write tid 1, pair 0, we=01, even word AAAA5555, while port 2 reads tid 1 reg 0 and port 3 reads reg 1. Results: AAAA5555 and 0.
- Parity: write tid 2 reg 4 with wr_inj=1, then all 4 ports read it. Every rd_perr=1 and perr_count=4. Pulse perr_clear and perr_count=0. Repeat 70 times and perr_count saturates at 255.
- Reset mid-sweep: assert rst at sweep cycle 500. ready stays 0, and writes during INIT are dropped. ready rises after a further 1024 cycles, and previously written registers read 0.
- Writes with wr_we=00 and wr_inj=1 leave data unchanged and raise no error on a subsequent read.

Source files
------------

// File: rtl/fpregfile_mt_pkg.sv
// Shared FP register-file types: clock bundle, FSM states, entry/response payloads
// and the byte-parity helpers.
package fpregfile_mt_pkg;

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned PAR_W   = WORD_W / 8;
   localparam int unsigned ENTRY_W = WORD_W + PAR_W;

   typedef struct packed {
      logic clk;
   } iu_clk_type;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } fprf_state_e;

   typedef struct packed {
      logic [PAR_W-1:0]  par;
      logic [WORD_W-1:0] data;
   } fprf_entry_t;

   typedef struct packed {
      logic [WORD_W-1:0] data;
      logic              perr;
   } fprf_rd_rsp_t;

   // Even parity per byte: the stored bit makes each 9-bit group have an even number of ones.
   function automatic logic [PAR_W-1:0] byte_parity(input logic [WORD_W-1:0] d);
      logic [PAR_W-1:0] p;
      for (int i = 0; i < int'(PAR_W); i++) begin
         p[i] = ^d[8*i +: 8];
      end
      return p;
   endfunction

   function automatic logic parity_err(input fprf_entry_t e);
      return |(byte_parity(e.data) ^ e.par);
   endfunction

endpackage

// File: rtl/fpregfile_bank.sv
// One-write / one-read storage bank with a registered read port.
// Only the output register is reset; the array contents are cleared by the owner's sweep.
module fpregfile_bank
   import fpregfile_mt_pkg::*;
#(
   parameter int unsigned  DEPTH = 1024,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  fprf_entry_t   wdata,
   input  logic [AW-1:0] raddr,
   output fprf_entry_t   rdata
);

   fprf_entry_t mem [DEPTH];
   fprf_entry_t rdata_d, rdata_q;

   always_comb begin
      rdata_d = mem[raddr];
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fpregfile_mt.sv
// Multi-threaded FP register file: NRD private read ports over replicated even/odd banks,
// one paired write port, write-to-read bypass, byte parity and a post-reset zeroing sweep.
module fpregfile_mt
   import fpregfile_mt_pkg::*;
#(
   parameter int unsigned  NTHREAD = 64,
   parameter int unsigned  NREG    = 32,
   parameter int unsigned  NRD     = 4,
   parameter int unsigned  PARITY  = 1,
   localparam int unsigned TW      = $clog2(NTHREAD),
   localparam int unsigned RW      = $clog2(NREG)
) (
   input  iu_clk_type            gclk,
   input  logic                  rst,
   input  logic [TW-1:0]         rd_tid  [NRD],
   input  logic [RW-1:0]         rd_reg  [NRD],
   output logic [WORD_W-1:0]     rd_data [NRD],
   output logic                  rd_perr [NRD],
   input  logic [TW-1:0]         wr_tid,
   input  logic [RW-2:0]         wr_pair,
   input  logic [1:0]            wr_we,
   input  logic [2*WORD_W-1:0]   wr_data,
   input  logic                  wr_inj,
   output logic                  ready,
   output logic [7:0]            perr_count,
   input  logic                  perr_clear
);

   localparam int unsigned DEPTH = NTHREAD * NREG / 2;
   localparam int unsigned AW    = TW + RW - 1;

   typedef struct packed {
      logic [TW-1:0] tid;
      logic [RW-1:0] rg;
   } rd_req_t;

   function automatic fprf_entry_t make_entry(input logic [WORD_W-1:0] w, input logic inj);
      fprf_entry_t e;
      e.data = w;
      e.par  = '0;
      if (PARITY != 0) begin
         e.par = byte_parity(w) ^ {{(PAR_W-1){1'b0}}, inj};
      end
      return e;
   endfunction

   fprf_state_e   state_q, state_d;
   logic [AW-1:0] sweep_q, sweep_d;
   logic [7:0]    perr_count_q, perr_count_d;

   logic          we_even, we_odd;
   logic [AW-1:0] waddr;
   fprf_entry_t   went_even, went_odd;

   rd_req_t       req     [NRD];
   logic [AW-1:0] raddr   [NRD];
   fprf_entry_t   even_rd [NRD];
   fprf_entry_t   odd_rd  [NRD];
   fprf_entry_t   byp_d   [NRD];
   fprf_entry_t   byp_q   [NRD];
   fprf_entry_t   rsel    [NRD];
   fprf_rd_rsp_t  rsp     [NRD];
   logic          hit_d   [NRD];
   logic          hit_q   [NRD];
   logic          sel_d   [NRD];
   logic          sel_q   [NRD];
   logic          zero_d  [NRD];
   logic          zero_q  [NRD];

   int unsigned   nerr;
   int unsigned   tot;

   // Sweep FSM and write-port steering; external writes are dropped while sweeping.
   always_comb begin
      state_d   = state_q;
      sweep_d   = sweep_q;
      we_even   = 1'b0;
      we_odd    = 1'b0;
      waddr     = {wr_tid, wr_pair};
      went_even = make_entry(wr_data[WORD_W-1:0], wr_inj);
      went_odd  = make_entry(wr_data[2*WORD_W-1:WORD_W], wr_inj);
      case (state_q)
         ST_INIT: begin
            we_even   = 1'b1;
            we_odd    = 1'b1;
            waddr     = sweep_q;
            went_even = '0;
            went_odd  = '0;
            if (sweep_q == AW'(DEPTH - 1)) begin
               state_d = ST_READY;
            end else begin
               sweep_d = sweep_q + AW'(1);
            end
         end
         ST_READY: begin
            we_even = wr_we[0];
            we_odd  = wr_we[1];
         end
      endcase
   end

   // Per-port address decode and same-cycle bypass detection.
   always_comb begin
      for (int p = 0; p < int'(NRD); p++) begin
         req[p]    = '{tid: rd_tid[p], rg: rd_reg[p]};
         raddr[p]  = {req[p].tid, req[p].rg[RW-1:1]};
         sel_d[p]  = req[p].rg[0];
         zero_d[p] = (state_q != ST_READY);
         hit_d[p]  = (state_q == ST_READY) && wr_we[req[p].rg[0]]
                     && (wr_tid == req[p].tid) && (wr_pair == req[p].rg[RW-1:1]);
         byp_d[p]  = req[p].rg[0] ? went_odd : went_even;
      end
   end

   for (genvar p = 0; p < int'(NRD); p++) begin : g_port
      fpregfile_bank #(.DEPTH(DEPTH)) u_even (
         .clk   (gclk.clk),
         .rst   (rst),
         .we    (we_even),
         .waddr (waddr),
         .wdata (went_even),
         .raddr (raddr[p]),
         .rdata (even_rd[p])
      );
      fpregfile_bank #(.DEPTH(DEPTH)) u_odd (
         .clk   (gclk.clk),
         .rst   (rst),
         .we    (we_odd),
         .waddr (waddr),
         .wdata (went_odd),
         .raddr (raddr[p]),
         .rdata (odd_rd[p])
      );
   end

   // Response select from registered state only: zero during init, then bypass, then bank.
   always_comb begin
      for (int p = 0; p < int'(NRD); p++) begin
         if (zero_q[p]) begin
            rsel[p] = '0;
         end else if (hit_q[p]) begin
            rsel[p] = byp_q[p];
         end else if (sel_q[p]) begin
            rsel[p] = odd_rd[p];
         end else begin
            rsel[p] = even_rd[p];
         end
         rsp[p].data = rsel[p].data;
         rsp[p].perr = (PARITY != 0) && !zero_q[p] && parity_err(rsel[p]);
         rd_data[p]  = rsp[p].data;
         rd_perr[p]  = rsp[p].perr;
      end
   end

   // Saturating error counter; clear wins and discards this cycle's errors.
   always_comb begin
      nerr = 0;
      for (int p = 0; p < int'(NRD); p++) begin
         nerr = nerr + 32'(rsp[p].perr);
      end
      tot          = 32'(perr_count_q) + nerr;
      perr_count_d = perr_count_q;
      if (perr_clear) begin
         perr_count_d = '0;
      end else if (state_q == ST_READY) begin
         perr_count_d = (tot > 32'd255) ? 8'hFF : 8'(tot);
      end
   end

   always_ff @(posedge gclk.clk) begin
      if (rst) begin
         state_q      <= ST_INIT;
         sweep_q      <= '0;
         perr_count_q <= '0;
         for (int p = 0; p < int'(NRD); p++) begin
            hit_q[p]  <= 1'b0;
            sel_q[p]  <= 1'b0;
            zero_q[p] <= 1'b1;
            byp_q[p]  <= '0;
         end
      end else begin
         state_q      <= state_d;
         sweep_q      <= sweep_d;
         perr_count_q <= perr_count_d;
         for (int p = 0; p < int'(NRD); p++) begin
            hit_q[p]  <= hit_d[p];
            sel_q[p]  <= sel_d[p];
            zero_q[p] <= zero_d[p];
            byp_q[p]  <= byp_d[p];
         end
      end
   end

   assign ready      = (state_q == ST_READY);
   assign perr_count = perr_count_q;

endmodule

// File: tb/tb_fpregfile_mt.sv
// Directed bench for fpregfile_mt: vector table for read/write/bypass/parity cycles,
// plus sequences for the init sweep, counter saturation and mid-sweep reset.
module tb_fpregfile_mt;
   import fpregfile_mt_pkg::*;

   localparam int unsigned NP = 4;

   logic        clk = 1'b0;
   iu_clk_type  gclk;
   logic        rst;
   logic [5:0]  rd_tid  [NP];
   logic [4:0]  rd_reg  [NP];
   logic [31:0] rd_data [NP];
   logic        rd_perr [NP];
   logic [5:0]  wr_tid;
   logic [3:0]  wr_pair;
   logic [1:0]  wr_we;
   logic [63:0] wr_data;
   logic        wr_inj;
   logic        ready;
   logic [7:0]  perr_count;
   logic        perr_clear;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;
   assign gclk.clk = clk;

   fpregfile_mt #(.NTHREAD(64), .NREG(32), .NRD(4), .PARITY(1)) dut (
      .gclk       (gclk),
      .rst        (rst),
      .rd_tid     (rd_tid),
      .rd_reg     (rd_reg),
      .rd_data    (rd_data),
      .rd_perr    (rd_perr),
      .wr_tid     (wr_tid),
      .wr_pair    (wr_pair),
      .wr_we      (wr_we),
      .wr_data    (wr_data),
      .wr_inj     (wr_inj),
      .ready      (ready),
      .perr_count (perr_count),
      .perr_clear (perr_clear)
   );

   // Port-indexed packed fields are written {p3, p2, p1, p0}.
   typedef struct {
      string          name;
      logic [5:0]     wtid;
      logic [3:0]     wpair;
      logic [1:0]     we;
      logic [63:0]    wdata;
      logic           inj;
      logic           clr;
      logic [3:0][5:0]  rtid;
      logic [3:0][4:0]  rreg;
      logic [3:0][31:0] exp_data;
      logic [3:0]     exp_perr;
      logic [7:0]     exp_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_write();
      wr_tid = '0; wr_pair = '0; wr_we = 2'b00; wr_data = '0; wr_inj = 1'b0;
   endtask

   task automatic set_reads(input logic [5:0] t, input logic [4:0] r);
      for (int p = 0; p < int'(NP); p++) begin
         rd_tid[p] = t;
         rd_reg[p] = r;
      end
   endtask

   function automatic logic [3:0] perr_vec();
      logic [3:0] v;
      for (int p = 0; p < int'(NP); p++) v[p] = rd_perr[p];
      return v;
   endfunction

   task automatic add(input string nm, input logic [5:0] wt, input logic [3:0] wp,
                      input logic [1:0] we, input logic [63:0] wd, input logic inj,
                      input logic clr, input logic [3:0][5:0] rt, input logic [3:0][4:0] rr,
                      input logic [3:0][31:0] ed, input logic [3:0] ep, input logic [7:0] ec);
      vec_t v;
      v.name = nm; v.wtid = wt; v.wpair = wp; v.we = we; v.wdata = wd; v.inj = inj;
      v.clr = clr; v.rtid = rt; v.rreg = rr; v.exp_data = ed; v.exp_perr = ep; v.exp_cnt = ec;
      vecs.push_back(v);
   endtask

   initial begin
      int n;

      add("v0_top_rd", 6'd5, 4'd3, 2'b11, 64'h40000000_3F800000, 1'b0, 1'b0,
          {6'd63, 6'd63, 6'd63, 6'd63}, {5'd31, 5'd31, 5'd31, 5'd31},
          {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0000, 8'd0);
      add("v1_pair_rd", 6'd0, 4'd0, 2'b00, 64'h0, 1'b0, 1'b0,
          {6'd4, 6'd5, 6'd5, 6'd5}, {5'd6, 5'd5, 5'd7, 5'd6},
          {32'h0, 32'h0, 32'h40000000, 32'h3F800000}, 4'b0000, 8'd0);
      add("v2_bypass", 6'd1, 4'd0, 2'b01, 64'hDEADBEEF_AAAA5555, 1'b0, 1'b0,
          {6'd1, 6'd1, 6'd0, 6'd5}, {5'd1, 5'd0, 5'd0, 5'd6},
          {32'h0, 32'hAAAA5555, 32'h0, 32'h3F800000}, 4'b0000, 8'd0);
      add("v3_we00_inj", 6'd5, 4'd3, 2'b00, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b0,
          {6'd5, 6'd5, 6'd1, 6'd1}, {5'd6, 5'd7, 5'd1, 5'd0},
          {32'h3F800000, 32'h40000000, 32'h0, 32'hAAAA5555}, 4'b0000, 8'd0);
      add("v4_after_we00", 6'd0, 4'd0, 2'b00, 64'h0, 1'b0, 1'b0,
          {6'd5, 6'd5, 6'd1, 6'd1}, {5'd6, 5'd7, 5'd1, 5'd0},
          {32'h3F800000, 32'h40000000, 32'h0, 32'hAAAA5555}, 4'b0000, 8'd0);
      add("v5_inj_byp", 6'd2, 4'd2, 2'b01, 64'h00000000_12345678, 1'b1, 1'b0,
          {6'd2, 6'd2, 6'd2, 6'd2}, {5'd4, 5'd4, 5'd4, 5'd4},
          {32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678}, 4'b1111, 8'd0);
      add("v6_inj_mem", 6'd0, 4'd0, 2'b00, 64'h0, 1'b0, 1'b0,
          {6'd2, 6'd2, 6'd2, 6'd2}, {5'd4, 5'd4, 5'd4, 5'd4},
          {32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678}, 4'b1111, 8'd4);
      add("v7_odd_clean", 6'd0, 4'd0, 2'b00, 64'h0, 1'b0, 1'b0,
          {6'd2, 6'd2, 6'd2, 6'd2}, {5'd5, 5'd5, 5'd5, 5'd5},
          {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0000, 8'd8);
      add("v8_clear", 6'd0, 4'd0, 2'b00, 64'h0, 1'b0, 1'b1,
          {6'd0, 6'd0, 6'd0, 6'd2}, {5'd0, 5'd0, 5'd0, 5'd4},
          {32'h0, 32'h0, 32'h0, 32'h12345678}, 4'b0001, 8'd0);
      add("v9_count1", 6'd0, 4'd0, 2'b00, 64'h0, 1'b0, 1'b0,
          {6'd0, 6'd0, 6'd0, 6'd0}, {5'd0, 5'd0, 5'd0, 5'd0},
          {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0000, 8'd1);
      add("v10_odd_inj", 6'd7, 4'd15, 2'b10, 64'h00000001_FFFFFFFF, 1'b1, 1'b1,
          {6'd0, 6'd7, 6'd7, 6'd7}, {5'd0, 5'd31, 5'd30, 5'd31},
          {32'h0, 32'h00000001, 32'h0, 32'h00000001}, 4'b0101, 8'd0);
      add("v11_odd_mem", 6'd0, 4'd0, 2'b00, 64'h0, 1'b0, 1'b0,
          {6'd1, 6'd5, 6'd7, 6'd7}, {5'd0, 5'd7, 5'd30, 5'd31},
          {32'hAAAA5555, 32'h40000000, 32'h0, 32'h00000001}, 4'b0001, 8'd2);

      // Reset state
      rst = 1'b1; perr_clear = 1'b0;
      idle_write();
      set_reads(6'd0, 5'd0);
      tick(); tick();
      chk("rst.rd_data0", 64'(rd_data[0]), 64'h0);
      chk("rst.rd_perr", 64'(perr_vec()), 64'h0);
      chk("rst.ready", 64'(ready), 64'h0);
      chk("rst.perr_count", 64'(perr_count), 64'h0);

      // Init sweep length
      rst = 1'b0;
      n = 0;
      while (!ready && n < 3000) begin
         tick();
         n++;
      end
      chk("init.cycles", 64'(n), 64'd1024);

      set_reads(6'd63, 5'd31);
      tick();
      chk("init.rd_t63r31", 64'(rd_data[3]), 64'h0);
      chk("init.perr_t63r31", 64'(perr_vec()), 64'h0);

      // Table-driven cycles
      foreach (vecs[i]) begin
         wr_tid = vecs[i].wtid; wr_pair = vecs[i].wpair; wr_we = vecs[i].we;
         wr_data = vecs[i].wdata; wr_inj = vecs[i].inj; perr_clear = vecs[i].clr;
         for (int p = 0; p < int'(NP); p++) begin
            rd_tid[p] = vecs[i].rtid[p];
            rd_reg[p] = vecs[i].rreg[p];
         end
         tick();
         for (int p = 0; p < int'(NP); p++) begin
            chk($sformatf("%s.data%0d", vecs[i].name, p), 64'(rd_data[p]), 64'(vecs[i].exp_data[p]));
         end
         chk({vecs[i].name, ".perr"}, 64'(perr_vec()), 64'(vecs[i].exp_perr));
         chk({vecs[i].name, ".count"}, 64'(perr_count), 64'(vecs[i].exp_cnt));
      end
      idle_write();
      perr_clear = 1'b0;

      // Saturation: all ports keep reading the poisoned word
      set_reads(6'd2, 5'd4);
      perr_clear = 1'b1;
      tick();
      chk("sat.cleared", 64'(perr_count), 64'h0);
      perr_clear = 1'b0;
      tick();
      chk("sat.first4", 64'(perr_count), 64'd4);
      for (int k = 0; k < 68; k++) tick();
      chk("sat.255", 64'(perr_count), 64'd255);
      chk("sat.perr", 64'(perr_vec()), 64'hF);
      set_reads(6'd0, 5'd0);
      perr_clear = 1'b1;
      tick();
      perr_clear = 1'b0;
      tick();
      chk("sat.after_clear", 64'(perr_count), 64'h0);

      // Reset mid-sweep; a write issued during the second sweep must be dropped
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_reads(6'd5, 5'd6);
      for (int k = 0; k < 500; k++) begin
         if (k == 100) begin
            wr_tid = 6'd5; wr_pair = 4'd3; wr_we = 2'b11; wr_data = 64'h12345678_9ABCDEF0;
         end else begin
            idle_write();
         end
         tick();
      end
      chk("mid.ready_low", 64'(ready), 64'h0);
      chk("mid.rd_zero", 64'(rd_data[0]), 64'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n = 0;
      while (!ready && n < 3000) begin
         if (n == 900) begin
            wr_tid = 6'd0; wr_pair = 4'd0; wr_we = 2'b11; wr_data = 64'h11111111_22222222;
         end else begin
            idle_write();
         end
         tick();
         n++;
      end
      idle_write();
      chk("mid.cycles", 64'(n), 64'd1024);
      rd_tid[0] = 6'd0; rd_reg[0] = 5'd0;
      rd_tid[1] = 6'd0; rd_reg[1] = 5'd1;
      rd_tid[2] = 6'd5; rd_reg[2] = 5'd6;
      rd_tid[3] = 6'd2; rd_reg[3] = 5'd4;
      tick();
      for (int p = 0; p < int'(NP); p++) begin
         chk($sformatf("mid.data%0d", p), 64'(rd_data[p]), 64'h0);
      end
      chk("mid.perr", 64'(perr_vec()), 64'h0);
      chk("mid.count", 64'(perr_count), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
